// File: rtl/adder_pkg.sv
// Shared constants for the byte accumulator path: FSM state encoding and datapath width.
package adder_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage : adder_pkg

// File: rtl/adder_8bits.sv
// Combinational 8-bit adder with carry-in and carry-out.
module adder_8bits
    import adder_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [BYTE_W:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};
    assign sum  = full[BYTE_W-1:0];
    assign cout = full[BYTE_W];

endmodule : adder_8bits

// File: rtl/byte_stream_accumulator.sv
// Accumulates a valid/ready byte stream per packet and presents sum, carry count and
// beat count on an output valid/ready handshake, one result per packet.
module byte_stream_accumulator
    import adder_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BYTE_W-1:0]  in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BYTE_W-1:0]  out_sum,
    output logic [COUNT_W-1:0] out_carries,
    output logic [COUNT_W-1:0] out_beats
);

    state_t              state, state_n;
    logic [BYTE_W-1:0]   acc, acc_n;
    logic [COUNT_W-1:0]  carries, carries_n;
    logic [COUNT_W-1:0]  beats, beats_n;
    logic [BYTE_W-1:0]   add_sum;
    logic                add_cout;
    logic                take_in;
    logic                take_out;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v,
                                                   input logic              en);
        return (en && (v != '1)) ? v + COUNT_W'(1) : v;
    endfunction

    adder_8bits u_adder (
        .a    (acc),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Handshake flags come from state alone, keeping ready/valid free of input loops.
    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign take_in   = in_valid && in_ready;
    assign take_out  = out_valid && out_ready;

    assign out_sum     = acc;
    assign out_carries = carries;
    assign out_beats   = beats;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_n   = state;
        acc_n     = acc;
        carries_n = carries;
        beats_n   = beats;

        if (clear) begin
            state_n   = IDLE;
            acc_n     = '0;
            carries_n = '0;
            beats_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_in) begin
                        acc_n     = in_data;
                        carries_n = '0;
                        beats_n   = COUNT_W'(1);
                        state_n   = in_last ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (take_in) begin
                        acc_n     = add_sum;
                        carries_n = sat_inc(carries, add_cout);
                        beats_n   = sat_inc(beats, 1'b1);
                        if (in_last) state_n = HOLD;
                    end
                end
                HOLD: begin
                    if (take_out) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            carries <= '0;
            beats   <= '0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            carries <= carries_n;
            beats   <= beats_n;
        end
    end

endmodule : byte_stream_accumulator
